// File: rtl/m_stage_pkg.sv
// Shared definitions for the m_stage merge stage: packet size, default
// synchronizer depth, FSM state encoding, source identifiers and the
// round-robin selection rule.
package m_stage_pkg;

  // Packet width shared by all stages of the pipeline.
  localparam int M_PACK_SIZE = 38;

  // Default number of flops on each asynchronous handshake input.
  localparam int M_SYNC_DEPTH = 2;

  // Merge FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,  // waiting for a synchronized request
    ST_IN_ACK  = 2'b01,  // granted source acknowledged, waiting for its release
    ST_OUT_REQ = 2'b10,  // request raised downstream, waiting for its ack
    ST_OUT_REL = 2'b11   // request dropped, waiting for downstream ack release
  } state_t;

  // Upstream source identifiers.
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  // Round-robin choice between two active-high requests. A lone requester
  // always wins; on a tie the source that did not win last time wins.
  // Callers only use the result when at least one request is set.
  function automatic src_t rr_pick(input logic req_a, input logic req_b,
                                   input src_t last);
    src_t pick;
    if (req_a && req_b) begin
      pick = (last == SRC_A) ? SRC_B : SRC_A;
    end else if (req_a) begin
      pick = SRC_A;
    end else begin
      pick = SRC_B;
    end
    return pick;
  endfunction

endpackage

// File: rtl/m_sync.sv
// Multi-flop synchronizer for one asynchronous, active-low handshake line.
// All flops reset to 1 so the line reads as idle while reset is applied
// and for SYNC cycles after it is released.
module m_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] chain;

  // Shift the raw line through SYNC flops; bit 0 is the first stage.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its input before any of them updates on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= (chain << 1) | SYNC'(d);
    end
  end

  assign q = chain[SYNC-1];

endmodule

// File: rtl/m_stage.sv
// Two-into-one merge stage for 4-phase active-low bundled-data handshakes.
// Requests from sources A and B and the downstream acknowledge are
// synchronized; a round-robin arbiter picks one source, its packet is
// registered onto PACKET_OUT and forwarded downstream.
module m_stage
  import m_stage_pkg::*;
#(
  parameter int PW   = M_PACK_SIZE,
  parameter int SYNC = M_SYNC_DEPTH
) (
  input  logic          CLK,
  input  logic          MR,
  input  logic          Send_in_a,
  output logic          Ack_out_a,
  input  logic [PW-1:0] PACKET_IN_a,
  input  logic          Send_in_b,
  output logic          Ack_out_b,
  input  logic [PW-1:0] PACKET_IN_b,
  output logic          Send_out,
  input  logic          Ack_in,
  output logic [PW-1:0] PACKET_OUT
);

  // Synchronized handshake lines (active-low, 1 = idle).
  logic send_a_s;
  logic send_b_s;
  logic ack_s;

  m_sync #(.SYNC(SYNC)) u_sync_a (
    .clk (CLK),
    .rst (MR),
    .d   (Send_in_a),
    .q   (send_a_s)
  );

  m_sync #(.SYNC(SYNC)) u_sync_b (
    .clk (CLK),
    .rst (MR),
    .d   (Send_in_b),
    .q   (send_b_s)
  );

  m_sync #(.SYNC(SYNC)) u_sync_ack (
    .clk (CLK),
    .rst (MR),
    .d   (Ack_in),
    .q   (ack_s)
  );

  // Registered state and outputs.
  state_t        state,      state_nxt;
  src_t          grant,      grant_nxt;
  src_t          last_grant, last_grant_nxt;
  logic          ack_a,      ack_a_nxt;
  logic          ack_b,      ack_b_nxt;
  logic          send,       send_nxt;
  logic [PW-1:0] packet,     packet_nxt;

  // Combinational helpers.
  logic req_a;
  logic req_b;
  logic granted_released;
  logic idle_eval;
  src_t pick;

  assign req_a            = ~send_a_s;
  assign req_b            = ~send_b_s;
  assign granted_released = (grant == SRC_A) ? send_a_s : send_b_s;

  // State register and registered handshake/data outputs.
  // NOTE: the packet register is reset like the control flops so PACKET_OUT
  // reads a defined zero after reset rather than stale data.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      state      <= ST_IDLE;
      grant      <= SRC_A;
      last_grant <= SRC_B;
      ack_a      <= 1'b1;
      ack_b      <= 1'b1;
      send       <= 1'b1;
      packet     <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      ack_a      <= ack_a_nxt;
      ack_b      <= ack_b_nxt;
      send       <= send_nxt;
      packet     <= packet_nxt;
    end
  end

  // Next-state, arbitration and output-update logic.
  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    ack_a_nxt      = ack_a;
    ack_b_nxt      = ack_b;
    send_nxt       = send;
    packet_nxt     = packet;
    idle_eval      = 1'b0;
    pick           = rr_pick(req_a, req_b, last_grant);

    case (state)
      ST_IDLE: begin
        idle_eval = 1'b1;
      end
      ST_IN_ACK: begin
        // Granted source has released its request: finish the upstream
        // handshake and offer the packet downstream.
        if (granted_released) begin
          ack_a_nxt = 1'b1;
          ack_b_nxt = 1'b1;
          send_nxt  = 1'b0;
          state_nxt = ST_OUT_REQ;
        end
      end
      ST_OUT_REQ: begin
        if (!ack_s) begin
          send_nxt  = 1'b1;
          state_nxt = ST_OUT_REL;
        end
      end
      ST_OUT_REL: begin
        // Downstream released: back to idle, and a waiting request may be
        // granted on this same edge.
        if (ack_s) begin
          state_nxt = ST_IDLE;
          idle_eval = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Grant one waiting source; the other source's acknowledge stays high.
    if (idle_eval && (req_a || req_b)) begin
      grant_nxt      = pick;
      last_grant_nxt = pick;
      state_nxt      = ST_IN_ACK;
      if (pick == SRC_A) begin
        packet_nxt = PACKET_IN_a;
        ack_a_nxt  = 1'b0;
      end else begin
        packet_nxt = PACKET_IN_b;
        ack_b_nxt  = 1'b0;
      end
    end
  end

  assign Ack_out_a  = ack_a;
  assign Ack_out_b  = ack_b;
  assign Send_out   = send;
  assign PACKET_OUT = packet;

endmodule
